// File: rtl/serial_pkg.sv
// Shared types and frame constants for the serial transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int DATA_BITS        = 8;
  localparam int START_BITS       = 1;
  localparam int STOP_BITS        = 1;
  localparam int BIT_CNT_W        = $clog2(DATA_BITS);
  localparam int CLKS_PER_BIT_DEF = 4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_transmit_if.sv
// Byte handshake plus serial line status between an upstream source and the transmitter.
interface serial_transmit_if;
  import serial_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_out;
  logic                 busy;

  modport master (output tx_data, tx_valid, input tx_ready, tx_out, busy);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_out, busy);
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period down counter: reloads CLKS_PER_BIT-1 on restart or after reaching 0; tick marks the last cycle.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (restart || r_cnt == '0) r_cnt <= RELOAD;
    else                              r_cnt <= r_cnt - 1'b1;
  end

  assign tick = (r_cnt == '0);
endmodule

// File: rtl/serial_transmit.sv
// UART-style transmitter: one-byte holding buffer feeding a shift register, start/data/[parity]/stop framing.
module serial_transmit
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_EN    = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  serial_transmit_if.slave bus
);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  tx_state_e              r_state, w_state_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0]   r_buf, w_buf_nxt;
  logic                   r_buf_full, w_buf_full_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic                   r_parity, w_parity_nxt;
  logic                   r_tx_out, w_tx_out_nxt;
  logic                   w_tick, w_restart, w_accept, w_drain;

  // Counter is held at reload while idle so START always gets a full bit period.
  assign w_restart = (r_state == ST_IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_buf_nxt      = r_buf;
    w_buf_full_nxt = r_buf_full;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_parity_nxt   = r_parity;
    w_tx_out_nxt   = 1'b1;
    w_drain        = 1'b0;
    w_accept       = bus.tx_valid && !r_buf_full;

    unique case (r_state)
      ST_IDLE:   if (r_buf_full) w_drain = 1'b1;
      ST_START:  if (w_tick) begin
                   w_state_nxt   = ST_DATA;
                   w_bit_cnt_nxt = '0;
                 end
      ST_DATA:   if (w_tick) begin
                   if (r_bit_cnt == LAST_BIT) begin
                     w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                   end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                     w_shift_nxt   = r_shift >> 1;
                   end
                 end
      ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_tick) begin
                   if (r_buf_full) w_drain = 1'b1;
                   else            w_state_nxt = ST_IDLE;
                 end
      default:   w_state_nxt = ST_IDLE;
    endcase

    // Parity is latched with the byte because the shift register is consumed bit by bit.
    if (w_drain) begin
      w_state_nxt    = ST_START;
      w_shift_nxt    = r_buf;
      w_parity_nxt   = even_parity(r_buf);
      w_bit_cnt_nxt  = '0;
      w_buf_full_nxt = 1'b0;
    end

    if (w_accept) begin
      w_buf_nxt      = bus.tx_data;
      w_buf_full_nxt = 1'b1;
    end

    unique case (w_state_nxt)
      ST_START:  w_tx_out_nxt = 1'b0;
      ST_DATA:   w_tx_out_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_out_nxt = w_parity_nxt;
      default:   w_tx_out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_bit_cnt  <= '0;
      r_parity   <= 1'b0;
      r_tx_out   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_parity   <= w_parity_nxt;
      r_tx_out   <= w_tx_out_nxt;
    end
  end

  assign bus.tx_ready = !r_buf_full;
  assign bus.tx_out   = r_tx_out;
  assign bus.busy     = (r_state != ST_IDLE) || r_buf_full;
endmodule

// File: tb/tb_serial_transmit.sv
// Bench for serial_transmit: dut0 without parity, dut1 with parity, checked against a frame-level model.
`timescale 1ns/1ps
module tb_serial_transmit;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tv [2];
  logic [7:0] td [2];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_transmit_if bus0();
  serial_transmit_if bus1();
  assign bus0.tx_valid = tv[0];
  assign bus0.tx_data  = td[0];
  assign bus1.tx_valid = tv[1];
  assign bus1.tx_data  = td[1];

  serial_transmit #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  serial_transmit #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Model: remaining cycles of the current frame, the frame byte, and the one-byte buffer.
  int         m_rem  [2] = '{0, 0};
  logic [7:0] m_cur  [2] = '{8'h00, 8'h00};
  logic [7:0] m_buf  [2] = '{8'h00, 8'h00};
  bit         m_full [2] = '{1'b0, 1'b0};

  function automatic int flen(input int d);
    return CPB * (10 + d);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int         r;
      bit         f;
      logic [7:0] c, b;
      r = m_rem[d]; f = m_full[d]; c = m_cur[d]; b = m_buf[d];
      if (!rst_n) begin
        r = 0; f = 1'b0;
      end else begin
        if (r > 0) r = r - 1;
        if (r == 0 && m_full[d]) begin c = m_buf[d]; r = flen(d); f = 1'b0; end
        if (tv[d] && !m_full[d]) begin b = td[d]; f = 1'b1; end
      end
      m_rem[d] <= r; m_full[d] <= f; m_cur[d] <= c; m_buf[d] <= b;
    end
  end

  function automatic logic exp_line(input int d);
    int bi;
    if (m_rem[d] == 0) return 1'b1;
    bi = (flen(d) - m_rem[d]) / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return m_cur[d][bi-1];
    if (d == 1 && bi == 9) return ^m_cur[d];
    return 1'b1;
  endfunction

  function automatic logic [2:0] mdl_st(input int d);
    return {exp_line(d), !m_full[d], (m_rem[d] != 0) || m_full[d]};
  endfunction

  function automatic logic [2:0] dut_st(input int d);
    if (d == 0) return {bus0.tx_out, bus0.tx_ready, bus0.busy};
    return {bus1.tx_out, bus1.tx_ready, bus1.busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every cycle, {tx_out, tx_ready, busy} of both DUTs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++)
        check($sformatf("model_dut%0d_cyc%0d", d, cyc), 32'(dut_st(d)), 32'(mdl_st(d)));
    end
  end

  typedef struct {
    int          d;
    logic [7:0]  data;
    logic [10:0] exp_bits;
    int          exp_len;
  } vec_t;
  vec_t vecs [7];

  // Sends one byte to an idle DUT; samples each bit mid-period and measures start-to-idle length.
  task automatic send_frame(input int d, input logic [7:0] data,
                            output logic [10:0] bits, output int len);
    logic [2:0] s;
    int         nb;
    nb = 10 + d; bits = '0; len = -1;
    @(negedge clk); tv[d] = 1'b1; td[d] = data;
    @(negedge clk); tv[d] = 1'b0;
    for (int m = 0; m < 200 && len < 0; m++) begin
      s = dut_st(d);
      if (m >= 2 && (m - 2) % CPB == 0 && (m - 2) / CPB < nb) bits[(m - 2) / CPB] = s[2];
      if (!s[0]) len = m - 1;
      else @(negedge clk);
    end
  endtask

  initial begin
    logic [10:0] bits;
    logic [2:0]  s;
    int          len, c0, k;

    tv[0] = 1'b0; tv[1] = 1'b0; td[0] = 8'h00; td[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state_dut0", 32'(dut_st(0)), 32'h6);
    check("reset_state_dut1", 32'(dut_st(1)), 32'h6);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{d:0, data:8'hA5, exp_bits:11'h34A, exp_len:40};
    vecs[1] = '{d:0, data:8'h00, exp_bits:11'h200, exp_len:40};
    vecs[2] = '{d:0, data:8'h3C, exp_bits:11'h278, exp_len:40};
    vecs[3] = '{d:1, data:8'h07, exp_bits:11'h60E, exp_len:44};
    vecs[4] = '{d:1, data:8'h03, exp_bits:11'h406, exp_len:44};
    vecs[5] = '{d:1, data:8'hFF, exp_bits:11'h5FE, exp_len:44};
    vecs[6] = '{d:1, data:8'h80, exp_bits:11'h700, exp_len:44};
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].data, bits, len);
      check($sformatf("vec%0d_bits", i), 32'(bits), 32'(vecs[i].exp_bits));
      check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      repeat (3) @(negedge clk);
    end

    // Back-to-back 0x00 then 0xFF with valid held: no idle gap, 80 cycles total.
    @(negedge clk); tv[0] = 1'b1; td[0] = 8'h00;
    @(negedge clk); c0 = cyc; td[0] = 8'hFF;
    s = dut_st(0);
    check("b2b_ready_low_when_full", 32'(s[1]), 32'h0);
    k = 0;
    while (!dut_st(0)[1] && k < 100) begin @(negedge clk); k++; end
    check("b2b_second_accept_offset", cyc - c0, 1);
    @(negedge clk); tv[0] = 1'b0;
    len = -1;
    for (int m = 0; m < 300 && len < 0; m++) begin
      s = dut_st(0);
      if (cyc == c0 + 40) check("b2b_first_stop", 32'(s[2]), 32'h1);
      if (cyc == c0 + 41) check("b2b_second_start", 32'(s[2]), 32'h0);
      if (!s[0]) len = cyc - c0 - 1;
      else @(negedge clk);
    end
    check("b2b_total_len", len, 80);
    repeat (3) @(negedge clk);

    // Buffer full: tx_ready stays low and changing tx_data must not disturb the queued byte.
    @(negedge clk); tv[1] = 1'b1; td[1] = 8'h81;
    @(negedge clk); td[1] = 8'h42;
    k = 0;
    while (!dut_st(1)[1] && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      td[1] = 8'($urandom);
      s = dut_st(1);
      check($sformatf("hold_ready_low_%0d", i), 32'(s[1]), 32'h0);
      @(negedge clk);
    end
    tv[1] = 1'b0;
    k = 0;
    while (dut_st(1)[0] && k < 300) begin @(negedge clk); k++; end
    check("hold_drained", 32'(dut_st(1)[0]), 32'h0);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 with a byte queued.
    @(negedge clk); tv[0] = 1'b1; td[0] = 8'h5A;
    @(negedge clk); c0 = cyc; td[0] = 8'hC3;
    k = 0;
    while (!dut_st(0)[1] && k < 100) begin @(negedge clk); k++; end
    @(negedge clk); tv[0] = 1'b0;
    k = 0;
    while (cyc < c0 + 18 && k < 100) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    @(negedge clk);
    s = dut_st(0);
    check("rst_mid_tx_out", 32'(s[2]), 32'h1);
    check("rst_mid_ready", 32'(s[1]), 32'h1);
    check("rst_mid_busy", 32'(s[0]), 32'h0);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!dut_st(0)[2] || dut_st(0)[0]) k++;
    end
    check("rst_no_further_frame", k, 0);

    // Randomized traffic on both DUTs with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      for (int d = 0; d < 2; d++) begin
        tv[d] = ($urandom_range(0, 2) == 0);
        td[d] = 8'($urandom);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; tv[0] = 1'b0; tv[1] = 1'b0;
    repeat (120) @(negedge clk);
    check("final_idle_dut0", 32'(dut_st(0)), 32'h6);
    check("final_idle_dut1", 32'(dut_st(1)), 32'h6);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
